// File: rtl/pipe_debug_monitor.sv
// Run-control and register-dump unit: counts a run, detects halt PC or cycle-limit
// timeout, then freezes the CPU and streams the register file over valid/ready.
module pipe_debug_monitor #(
  parameter int              AW      = 32,
  parameter int              DW      = 32,
  parameter int              NREG    = 32,
  parameter int              RSELW   = 5,
  parameter logic [AW-1:0]   HALT_PC = 32'h000000ff,
  parameter int              MAX_CYC = 1024,
  parameter int              CNTW    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    pc,
  input  logic             retire,
  output logic             cpu_hold,
  output logic [RSELW-1:0] reg_sel,
  input  logic [DW-1:0]    reg_data,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [RSELW-1:0] dump_idx,
  output logic [DW-1:0]    dump_data,
  output logic [CNTW-1:0]  cycle_cnt,
  output logic [CNTW-1:0]  retire_cnt,
  output logic             timeout,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DUMP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // One extra bit so the index can hold NREG as the "all loaded" marker.
  localparam int              IDXW     = RSELW + 1;
  localparam logic [IDXW-1:0] NREG_I   = IDXW'(NREG);
  localparam logic [CNTW-1:0] CYC_LAST = CNTW'(MAX_CYC - 1);
  localparam logic [CNTW-1:0] CNT_SAT  = {CNTW{1'b1}};

  state_t           state_r;
  state_t           state_nxt_s;
  logic [IDXW-1:0]  idx_r;
  logic             load_s;
  logic             last_hs_s;
  logic             halt_s;
  logic             tmo_s;
  logic             clear_s;
  logic [CNTW-1:0]  cycle_cnt_r;
  logic [CNTW-1:0]  retire_cnt_r;
  logic             timeout_r;
  logic             done_r;
  logic             cpu_hold_r;
  logic             dump_valid_r;
  logic [RSELW-1:0] dump_idx_r;
  logic [DW-1:0]    dump_data_r;
  logic [RSELW-1:0] reg_sel_s;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    last_hs_s   = 1'b0;
    halt_s      = 1'b0;
    tmo_s       = 1'b0;
    clear_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        clear_s = 1'b1;
        if (start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Halt has priority over the cycle limit in the same cycle.
        halt_s = (pc == HALT_PC);
        tmo_s  = !halt_s && (cycle_cnt_r == CYC_LAST);
        if (halt_s || tmo_s) begin
          state_nxt_s = ST_DUMP;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DUMP: begin
        load_s    = (idx_r != NREG_I) && (!dump_valid_r || dump_ready);
        last_hs_s = (idx_r == NREG_I) && dump_valid_r && dump_ready;
        if (last_hs_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DUMP;
        end
      end
      ST_DONE: begin
        if (start) begin
          clear_s     = 1'b1;
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Run counters and timeout flag; frozen outside RUN unless cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_r  <= {CNTW{1'b0}};
      retire_cnt_r <= {CNTW{1'b0}};
      timeout_r    <= 1'b0;
    end else if (clear_s) begin
      cycle_cnt_r  <= {CNTW{1'b0}};
      retire_cnt_r <= {CNTW{1'b0}};
      timeout_r    <= 1'b0;
    end else if (state_r == ST_RUN) begin
      if (cycle_cnt_r != CNT_SAT) begin
        cycle_cnt_r <= cycle_cnt_r + CNTW'(1);
      end
      if (retire && (retire_cnt_r != CNT_SAT)) begin
        retire_cnt_r <= retire_cnt_r + CNTW'(1);
      end
      if (tmo_s) begin
        timeout_r <= 1'b1;
      end
    end
  end

  // Status outputs registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_hold_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      cpu_hold_r <= (state_nxt_s == ST_DUMP) || (state_nxt_s == ST_DONE);
      done_r     <= (state_nxt_s == ST_DONE);
    end
  end

  // Dump read index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r <= {IDXW{1'b0}};
    end else if (state_r != ST_DUMP) begin
      idx_r <= {IDXW{1'b0}};
    end else if (load_s) begin
      idx_r <= idx_r + IDXW'(1);
    end
  end

  // Dump output register; holds while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dump_valid_r <= 1'b0;
      dump_idx_r   <= {RSELW{1'b0}};
      dump_data_r  <= {DW{1'b0}};
    end else if (load_s) begin
      dump_valid_r <= 1'b1;
      dump_idx_r   <= idx_r[RSELW-1:0];
      dump_data_r  <= (idx_r == {IDXW{1'b0}}) ? {DW{1'b0}} : reg_data;
    end else if (last_hs_s) begin
      dump_valid_r <= 1'b0;
    end
  end

  // Register-file debug select; parked at 0 outside the dump.
  always_comb begin
    reg_sel_s = {RSELW{1'b0}};
    if (state_r == ST_DUMP) begin
      reg_sel_s = idx_r[RSELW-1:0];
    end else begin
      reg_sel_s = {RSELW{1'b0}};
    end
  end

  assign cpu_hold   = cpu_hold_r;
  assign reg_sel    = reg_sel_s;
  assign dump_valid = dump_valid_r;
  assign dump_idx   = dump_idx_r;
  assign dump_data  = dump_data_r;
  assign cycle_cnt  = cycle_cnt_r;
  assign retire_cnt = retire_cnt_r;
  assign timeout    = timeout_r;
  assign done       = done_r;

endmodule

// File: tb/tb_pipe_debug_monitor.sv
// Scoreboard bench for pipe_debug_monitor: instance a uses the default cycle limit,
// instance b a 16-cycle limit for the timeout cases.
module tb_pipe_debug_monitor;

  localparam int            AW      = 32;
  localparam int            DW      = 32;
  localparam int            NREG    = 32;
  localparam int            RSELW   = 5;
  localparam int            CNTW    = 32;
  localparam logic [AW-1:0] HALT    = 32'h000000ff;
  localparam int            EW      = DW + RSELW;

  logic clk, rst, start_a, start_b, retire, dump_ready;
  logic [AW-1:0] pc;
  logic [DW-1:0] reg_base;

  logic cpu_hold_a, dump_valid_a, timeout_a, done_a;
  logic [RSELW-1:0] reg_sel_a, dump_idx_a;
  logic [DW-1:0] reg_data_a, dump_data_a;
  logic [CNTW-1:0] cycle_cnt_a, retire_cnt_a;

  logic cpu_hold_b, dump_valid_b, timeout_b, done_b;
  logic [RSELW-1:0] reg_sel_b, dump_idx_b;
  logic [DW-1:0] reg_data_b, dump_data_b;
  logic [CNTW-1:0] cycle_cnt_b, retire_cnt_b;

  logic [EW-1:0] exp_a[$];
  logic [EW-1:0] exp_b[$];
  int n_tests = 0;
  int n_fail  = 0;
  int ncyc, nret;
  bit bp_mode;

  // Register file model: reg 0 returns junk so the forced zero is visible.
  assign reg_data_a = (reg_sel_a == 5'd0) ? 32'hDEAD_BEEF : reg_base + DW'(reg_sel_a);
  assign reg_data_b = (reg_sel_b == 5'd0) ? 32'hDEAD_BEEF : reg_base + DW'(reg_sel_b);

  pipe_debug_monitor #(.AW(AW), .DW(DW), .NREG(NREG), .RSELW(RSELW), .HALT_PC(HALT),
                       .MAX_CYC(1024), .CNTW(CNTW)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .pc(pc), .retire(retire),
    .cpu_hold(cpu_hold_a), .reg_sel(reg_sel_a), .reg_data(reg_data_a),
    .dump_valid(dump_valid_a), .dump_ready(dump_ready), .dump_idx(dump_idx_a),
    .dump_data(dump_data_a), .cycle_cnt(cycle_cnt_a), .retire_cnt(retire_cnt_a),
    .timeout(timeout_a), .done(done_a));

  pipe_debug_monitor #(.AW(AW), .DW(DW), .NREG(NREG), .RSELW(RSELW), .HALT_PC(HALT),
                       .MAX_CYC(16), .CNTW(CNTW)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .pc(pc), .retire(retire),
    .cpu_hold(cpu_hold_b), .reg_sel(reg_sel_b), .reg_data(reg_data_b),
    .dump_valid(dump_valid_b), .dump_ready(dump_ready), .dump_idx(dump_idx_b),
    .dump_data(dump_data_b), .cycle_cnt(cycle_cnt_b), .retire_cnt(retire_cnt_b),
    .timeout(timeout_b), .done(done_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] exp_entry(input int i);
    logic [DW-1:0] d;
    d = (i == 0) ? {DW{1'b0}} : reg_base + DW'(i);
    return {RSELW'(i), d};
  endfunction

  task automatic push_exp(input bit b, input int n);
    for (int i = 0; i < n; i++) begin
      if (b) exp_b.push_back(exp_entry(i));
      else   exp_a.push_back(exp_entry(i));
    end
  endtask

  task automatic pulse_start(input bit b);
    @(posedge clk); #1;
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    ncyc = 0;
    nret = 0;
  endtask

  // One RUN cycle with the given PC; retire is either always 1 or random.
  task automatic step_run(input logic [AW-1:0] p, input bit rnd);
    pc     = p;
    retire = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    ncyc++;
    nret += int'(retire);
  endtask

  task automatic wait_done(input bit b, input string tag);
    int k;
    k = 0;
    while (!(b ? done_b : done_a) && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq(tag, b ? done_b : done_a, 1'b1);
    check_eq({tag, "_queue_left"}, b ? exp_b.size() : exp_a.size(), 0);
  endtask

  // Consumer ready: always high, or the 1,0,0,1 backpressure pattern.
  initial begin
    int ph;
    ph = 0;
    dump_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_mode) begin
        dump_ready = (ph == 0) || (ph == 3);
        ph = (ph + 1) % 4;
      end else begin
        dump_ready = 1'b1;
        ph = 0;
      end
    end
  end

  // Monitor a: pop and compare each accepted entry, check stability under stall.
  initial begin
    logic [EW-1:0] e;
    logic stall;
    logic [RSELW-1:0] si;
    logic [DW-1:0] sd;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (stall && !rst) begin
        check_eq("a_stall_valid", dump_valid_a, 1'b1);
        check_eq("a_stall_idx", dump_idx_a, si);
        check_eq("a_stall_data", dump_data_a, sd);
      end
      stall = 1'b0;
      if (!rst && dump_valid_a) begin
        if (!dump_ready) begin
          stall = 1'b1; si = dump_idx_a; sd = dump_data_a;
        end else if (exp_a.size() == 0) begin
          check_eq("a_unexpected_entry", exp_a.size(), 1);
        end else begin
          e = exp_a.pop_front();
          check_eq("a_idx", dump_idx_a, e[EW-1:DW]);
          check_eq("a_data", dump_data_a, e[DW-1:0]);
        end
      end
    end
  end

  // Monitor b.
  initial begin
    logic [EW-1:0] e;
    logic stall;
    logic [RSELW-1:0] si;
    logic [DW-1:0] sd;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (stall && !rst) begin
        check_eq("b_stall_valid", dump_valid_b, 1'b1);
        check_eq("b_stall_idx", dump_idx_b, si);
        check_eq("b_stall_data", dump_data_b, sd);
      end
      stall = 1'b0;
      if (!rst && dump_valid_b) begin
        if (!dump_ready) begin
          stall = 1'b1; si = dump_idx_b; sd = dump_data_b;
        end else if (exp_b.size() == 0) begin
          check_eq("b_unexpected_entry", exp_b.size(), 1);
        end else begin
          e = exp_b.pop_front();
          check_eq("b_idx", dump_idx_b, e[EW-1:DW]);
          check_eq("b_data", dump_data_b, e[DW-1:0]);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; retire = 1'b0;
    pc = '0; reg_base = '0; bp_mode = 1'b0; ncyc = 0; nret = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_hold", cpu_hold_a, 1'b0);
    check_eq("rst_valid", dump_valid_a, 1'b0);
    check_eq("rst_done", done_a, 1'b0);
    check_eq("rst_cycle", cycle_cnt_a, 0);
    check_eq("rst_regsel", reg_sel_a, 0);
    @(negedge clk);
    rst = 1'b0;

    // Halt at PC with one retire per cycle and ready held high.
    reg_base = 32'h5500_0000;
    push_exp(1'b0, NREG);
    pulse_start(1'b0);
    step_run(32'h0, 1'b0);
    check_eq("t1_cycle_first", cycle_cnt_a, 1);
    for (int p = 4; p <= 252; p += 4) step_run(AW'(p), 1'b0);
    check_eq("t1_hold_pre", cpu_hold_a, 1'b0);
    step_run(HALT, 1'b0);
    pc = '0;
    check_eq("t1_hold", cpu_hold_a, 1'b1);
    check_eq("t1_cycle", cycle_cnt_a, 65);
    check_eq("t1_retire_eq", retire_cnt_a, cycle_cnt_a);
    check_eq("t1_timeout", timeout_a, 1'b0);
    check_eq("t1_valid_h", dump_valid_a, 1'b0);
    for (int k = 1; k <= NREG + 1; k++) begin
      @(posedge clk); #1;
      if (k == 1) check_eq("t1_first_idx", {dump_valid_a, dump_idx_a}, {1'b1, 5'd0});
      if (k == NREG) check_eq("t1_last", {dump_valid_a, done_a, dump_idx_a}, {2'b10, 5'd31});
      if (k == NREG + 1) check_eq("t1_done", {done_a, dump_valid_a}, 2'b10);
    end
    check_eq("t1_queue_left", exp_a.size(), 0);

    // Restart from DONE clears everything.
    pulse_start(1'b0);
    check_eq("t2_done_clr", done_a, 1'b0);
    check_eq("t2_cycle_clr", cycle_cnt_a, 0);
    check_eq("t2_retire_clr", retire_cnt_a, 0);
    check_eq("t2_hold_clr", cpu_hold_a, 1'b0);

    // Backpressure dump, start pulses ignored in RUN and DUMP.
    reg_base = 32'hA000_0000;
    push_exp(1'b0, NREG);
    bp_mode = 1'b1;
    repeat (3) step_run(32'h10, 1'b1);
    start_a = 1'b1;
    step_run(32'h10, 1'b1);
    start_a = 1'b0;
    check_eq("t3_start_in_run", cycle_cnt_a, ncyc);
    repeat (2) step_run(32'h14, 1'b1);
    step_run(HALT, 1'b1);
    pc = '0;
    check_eq("t3_cycle", cycle_cnt_a, ncyc);
    check_eq("t3_retire", retire_cnt_a, nret);
    repeat (5) @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    check_eq("t3_start_in_dump", cpu_hold_a, 1'b1);
    wait_done(1'b0, "t3_done");
    check_eq("t3_cycle_frozen", cycle_cnt_a, ncyc);
    bp_mode = 1'b0;

    // Reset after entry 10 is accepted.
    reg_base = 32'h3300_0000;
    push_exp(1'b0, 11);
    pulse_start(1'b0);
    repeat (2) step_run(32'h20, 1'b0);
    step_run(HALT, 1'b0);
    pc = '0;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      if (dump_valid_a && dump_ready && dump_idx_a == 5'd10) found = 1'b1;
    end
    check_eq("t4_seen_idx10", found, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check_eq("t4_valid_rst", dump_valid_a, 1'b0);
    check_eq("t4_hold_rst", cpu_hold_a, 1'b0);
    check_eq("t4_done_rst", done_a, 1'b0);
    check_eq("t4_queue_left", exp_a.size(), 0);
    @(negedge clk); rst = 1'b0;
    reg_base = 32'h7700_0000;
    push_exp(1'b0, NREG);
    pulse_start(1'b0);
    repeat (4) step_run(32'h30, 1'b0);
    step_run(HALT, 1'b0);
    pc = '0;
    wait_done(1'b0, "t4_redump_done");

    // Timeout on instance b.
    reg_base = 32'h0B00_0000;
    push_exp(1'b1, NREG);
    pulse_start(1'b1);
    repeat (15) step_run(32'h40, 1'b0);
    check_eq("t5_hold_pre", cpu_hold_b, 1'b0);
    check_eq("t5_cycle_pre", cycle_cnt_b, 15);
    step_run(32'h40, 1'b0);
    check_eq("t5_cycle", cycle_cnt_b, 16);
    check_eq("t5_timeout", timeout_b, 1'b1);
    check_eq("t5_hold", cpu_hold_b, 1'b1);
    check_eq("t5_retire", retire_cnt_b, nret);
    wait_done(1'b1, "t5_done");
    check_eq("t5_timeout_frozen", timeout_b, 1'b1);
    check_eq("t5_cycle_frozen", cycle_cnt_b, 16);

    // Halt and cycle limit in the same cycle: halt wins.
    reg_base = 32'h0C00_0000;
    push_exp(1'b1, NREG);
    pulse_start(1'b1);
    check_eq("t6_timeout_clr", timeout_b, 1'b0);
    check_eq("t6_done_clr", done_b, 1'b0);
    repeat (15) step_run(32'h40, 1'b0);
    step_run(HALT, 1'b0);
    pc = '0;
    check_eq("t6_timeout", timeout_b, 1'b0);
    check_eq("t6_hold", cpu_hold_b, 1'b1);
    check_eq("t6_cycle", cycle_cnt_b, 16);
    wait_done(1'b1, "t6_done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
